// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Bus widths, encodings and bus layouts shared by the MEM stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int unsigned c_es_to_ms_bus_wd = 205;
    localparam int unsigned c_ms_to_ws_bus_wd = 200;
    localparam int unsigned c_ms_forward_wd   = 40;

    localparam logic [1:0] c_mem_b = 2'd0;
    localparam logic [1:0] c_mem_h = 2'd1;
    localparam logic [1:0] c_mem_w = 2'd2;

    localparam logic [1:0] c_ms_idle    = 2'd0;
    localparam logic [1:0] c_ms_wait    = 2'd1;
    localparam logic [1:0] c_ms_discard = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic        ertn;
        logic [4:0]  dest;
        logic        rf_we;
        logic        res_from_csr;
        logic        res_from_mem;
        logic [1:0]  mem_size;
        logic        mem_signed;
        logic        mem_req;
        logic [31:0] alu_result;
        logic        excp;
        logic [15:0] excp_num;
        logic [31:0] err_addr;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wdata;
    } es_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        ertn;
        logic [4:0]  dest;
        logic        rf_we;
        logic        res_from_csr;
        logic [31:0] final_result;
        logic        excp;
        logic [15:0] excp_num;
        logic [31:0] err_addr;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wdata;
    } ws_bus_t;

endpackage
`default_nettype wire

// File: rtl/mem_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_load_align
// Description : Selects the addressed byte/half/word lane of load data and
//               sign- or zero-extends it to 32 bits. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_size)
            c_mem_b: o_result = {{24{i_signed & w_byte[7]}}, w_byte};
            c_mem_h: o_result = {{16{i_signed & w_half[15]}}, w_half};
            default: o_result = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : LoongArch MEM stage - waits for the data-channel response,
//               aligns load data, and drops responses orphaned by a flush.
//               Define MS_FWD_LOAD_EN to forward load data to ID in the
//               same cycle data_ok arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    output logic                         ms_allowin,
    input  logic                         es_to_ms_valid,
    input  logic [c_es_to_ms_bus_wd-1:0] es_to_ms_bus,
    input  logic                         ws_allowin,
    output logic                         ms_to_ws_valid,
    output logic [c_ms_to_ws_bus_wd-1:0] ms_to_ws_bus,
    input  logic                         data_sram_data_ok,
    input  logic [31:0]                  data_sram_rdata,
    input  logic                         excp_flush,
    input  logic                         ertn_flush,
    output logic                         ms_ex,
    output logic [c_ms_forward_wd-1:0]   ms_forward
);

    es_bus_t     w_es_in;
    es_bus_t     r_ms_bus;
    ws_bus_t     w_ws_bus;
    logic        r_ms_valid;
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_data_ok_seen;
    logic [31:0] r_data_buf;

    logic        w_flush;
    logic        w_data_ok_now;
    logic        w_need_wait;
    logic        w_ready_go;
    logic        w_accept;
    logic        w_leave;
    logic        w_data_ready_now;
    logic        w_load_busy;
    logic [31:0] w_load_raw;
    logic [31:0] w_load_ext;
    logic [31:0] w_final;

    assign w_es_in       = es_bus_t'(es_to_ms_bus);
    assign w_flush       = excp_flush | ertn_flush;
    assign w_data_ok_now = (r_state == c_ms_wait) && data_sram_data_ok;
    assign w_need_wait   = r_ms_valid && r_ms_bus.mem_req;
    assign w_ready_go    = !w_need_wait || r_data_ok_seen || w_data_ok_now;

    // DISCARD blocks intake so a new request cannot overtake the dropped response
    assign ms_allowin     = (r_state != c_ms_discard) &&
                            (!r_ms_valid || (w_ready_go && ws_allowin));
    assign w_accept       = es_to_ms_valid && ms_allowin;
    assign w_leave        = r_ms_valid && w_ready_go && ws_allowin;
    assign ms_to_ws_valid = r_ms_valid && w_ready_go && !w_flush;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ms_idle: begin
                if (w_accept && !w_flush && w_es_in.mem_req)
                    w_state_nxt = c_ms_wait;
            end
            c_ms_wait: begin
                // A response already consumed leaves nothing in flight to drop
                if (w_flush)
                    w_state_nxt = (data_sram_data_ok || r_data_ok_seen) ? c_ms_idle : c_ms_discard;
                else if (w_leave)
                    w_state_nxt = (w_accept && w_es_in.mem_req) ? c_ms_wait : c_ms_idle;
            end
            c_ms_discard: begin
                if (data_sram_data_ok)
                    w_state_nxt = c_ms_idle;
            end
            default: w_state_nxt = c_ms_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_ms_idle;
            r_ms_valid     <= 1'b0;
            r_ms_bus       <= '0;
            r_data_ok_seen <= 1'b0;
            r_data_buf     <= 32'd0;
        end else begin
            r_state <= w_state_nxt;

            if (w_flush)
                r_ms_valid <= 1'b0;
            else if (ms_allowin)
                r_ms_valid <= es_to_ms_valid;

            if (w_accept)
                r_ms_bus <= w_es_in;

            if (w_flush || w_leave)
                r_data_ok_seen <= 1'b0;
            else if (w_data_ok_now)
                r_data_ok_seen <= 1'b1;

            if (w_data_ok_now)
                r_data_buf <= data_sram_rdata;
        end
    end

    assign w_load_raw = r_data_ok_seen ? r_data_buf : data_sram_rdata;

    mem_stage_load_align u_load_align (
        .i_rdata  (w_load_raw),
        .i_offset (r_ms_bus.alu_result[1:0]),
        .i_size   (r_ms_bus.mem_size),
        .i_signed (r_ms_bus.mem_signed),
        .o_result (w_load_ext)
    );

    assign w_final = r_ms_bus.res_from_mem ? w_load_ext : r_ms_bus.alu_result;

    always_comb begin
        w_ws_bus              = '0;
        w_ws_bus.pc           = r_ms_bus.pc;
        w_ws_bus.ertn         = r_ms_bus.ertn;
        w_ws_bus.dest         = r_ms_bus.dest;
        w_ws_bus.rf_we        = r_ms_bus.rf_we;
        w_ws_bus.res_from_csr = r_ms_bus.res_from_csr;
        w_ws_bus.final_result = w_final;
        w_ws_bus.excp         = r_ms_bus.excp;
        w_ws_bus.excp_num     = r_ms_bus.excp_num;
        w_ws_bus.err_addr     = r_ms_bus.err_addr;
        w_ws_bus.csr_we       = r_ms_bus.csr_we;
        w_ws_bus.csr_num      = r_ms_bus.csr_num;
        w_ws_bus.csr_wmask    = r_ms_bus.csr_wmask;
        w_ws_bus.csr_wdata    = r_ms_bus.csr_wdata;
    end

    assign ms_to_ws_bus = w_ws_bus;
    assign ms_ex        = r_ms_valid && (r_ms_bus.excp || r_ms_bus.ertn);

`ifdef MS_FWD_LOAD_EN
    assign w_data_ready_now = r_data_ok_seen || w_data_ok_now;
`else
    // Registered only: keeps the rdata-to-ID path short at the cost of a stall cycle
    assign w_data_ready_now = r_data_ok_seen;
`endif

    assign w_load_busy = r_ms_valid && r_ms_bus.res_from_mem && !w_data_ready_now;
    assign ms_forward  = {r_ms_valid, r_ms_valid & r_ms_bus.rf_we, r_ms_bus.dest,
                          w_final, w_load_busy};

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage LoongArch pipeline. Sits between the execute stage and the writeback stage.
- Takes the registered EX-stage bus and waits for the load/store response on the SRAM-like data channel. Aligns and extends load data.
- Passes exception/CSR fields through unchanged and produces the MEM-to-WB bus with valid/allowin handshaking.
- Handles flush (exception or ertn) while a data request is outstanding by discarding the orphaned response.

Parameters:
- none (bus widths come from myCPU.h macros: ES_TO_MS_BUS_WD=205, MS_TO_WS_BUS_WD=200, MS_FORWARD_WD=40)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ms_allowin  out  1  MEM can accept from EX this cycle
- es_to_ms_valid  in  1  EX bus valid
- es_to_ms_bus  in  205  {pc32, ertn, dest5, rf_we, res_from_csr, res_from_mem, mem_size2, mem_signed, mem_req, alu_result32, excp, excp_num16, err_addr32, csr_we, csr_num14, csr_wmask32, csr_wdata32}
- ws_allowin  in  1  WB ready
- ms_to_ws_valid  out  1  WB bus valid
- ms_to_ws_bus  out  200  {pc32, ertn, dest5, rf_we, res_from_csr, final_result32, excp, excp_num16, err_addr32, csr_we, csr_num14, csr_wmask32, csr_wdata32}
- data_sram_data_ok  in  1  response for the oldest outstanding data request
- data_sram_rdata  in  32  read data, valid with data_ok
- excp_flush  in  1  WB exception flush
- ertn_flush  in  1  WB ertn flush
- ms_ex  out  1  MEM holds valid excp or ertn; EX suppresses new store requests
- ms_forward  out  40  {ms_valid, rf_we, dest5, result32, ms_load_busy}

Behaviour:
- Reset: ms_valid=0, state=IDLE, ms_to_ws_valid=0, ms_ex=0, ms_forward=0, bus register=0.
- ms_valid: flush → 0; else if ms_allowin → es_to_ms_valid. The bus register is loaded when es_to_ms_valid && ms_allowin.
- ms_ready_go = !need_wait || data_ok_seen, where need_wait = ms_valid && mem_req.
- ms_allowin = !ms_valid || (ms_ready_go && ws_allowin). ms_to_ws_valid = ms_valid && ms_ready_go && !flush.
- State machine states: IDLE, WAIT, DISCARD.
  - IDLE→WAIT when an entry with mem_req=1 is accepted.
  - In WAIT, data_ok captures rdata into data_buf and sets data_ok_seen. The data_ok cycle itself also counts as ready (combinational bypass). Move to IDLE when the entry leaves to WB.
  - WAIT with flush and no data_ok in the same cycle → DISCARD.
  - DISCARD: the next data_ok is dropped, then →IDLE.
  - While in DISCARD, ms_allowin=0, so new requests stay ordered behind the dropped response.
- data_ok_seen clears when the entry leaves.
- Flush in the same cycle as data_ok: the response is consumed and the state goes to IDLE (no DISCARD).
- Reset mid-WAIT/DISCARD → IDLE. The SRAM side is reset in the same cycle.
- Load alignment: lane = alu_result[1:0].
  - size 0 (byte): byte at lane*8.
  - size 1 (half): half at lane[1]*16.
  - size 2 (word): full word.
  - mem_signed selects sign vs zero extension to 32 bits.
- final_result = res_from_mem ? extended load : alu_result.
- Exceptions: excp/excp_num/err_addr/ertn/csr fields pass through unchanged. MEM raises no new exceptions.
- ms_ex = ms_valid && (excp || ertn).
- ms_forward.ms_load_busy = ms_valid && res_from_mem && !data_ready_now. The ID stage must stall on it.

Optional Feature:
- MS_FWD_LOAD_EN defined: data_ready_now includes the data_ok cycle, so load data is forwarded to ID in the cycle data_ok arrives.
- MS_FWD_LOAD_EN undefined: data_ready_now = data_ok_seen only (registered). A dependent instruction waits one extra cycle; this shortens the data_rdata→ID path.

Decomposition:
- myCPU.h: bus width macros, mem_size encodings (MEM_B=0, MEM_H=1, MEM_W=2), state encodings (MS_IDLE, MS_WAIT, MS_DISCARD).
- One natural sub-module: load_align (pure combinational lane select and extend, inputs rdata/offset/size/signed), reusable by a future unaligned-access path.

Test Plan:
- Non-memory ALU op, alu_result=0x12345678, ws_allowin=1 → ms_to_ws_valid one cycle after acceptance, final_result=0x12345678.
- ld.b, addr low bits 2'b11, rdata=0x80FF_0000, data_ok 3 cycles late → stalls 3 cycles, final_result=0xFFFFFF80. Same case as ld.bu → 0x00000080.
- ld.h offset 2, rdata=0x8001_1234, signed → 0xFFFF8001. data_ok while ws_allowin=0 → data buffered, delivered on ws_allowin=1.
- Load in WAIT, excp_flush pulse, data_ok 2 cycles later with 0xDEADBEEF → state goes DISCARD, no ms_to_ws_valid. The next load's data_ok (0x11) is delivered correctly.
- Flush and data_ok in the same cycle → state IDLE directly; the following load is not blocked.
- Entry with excp=1, excp_num bit14 → ms_ex=1 and the fields are forwarded to WB bit-exact. Reset asserted mid-WAIT → all outputs 0 the next cycle.
